// File: rtl/hazard_unit_md.sv
// Hazard detection for a pipelined MIPS-style core with a multi-cycle
// multiply/divide unit. It combines Tuse/Tnew data hazards with a busy
// counter for the md unit, and keeps saturating stall statistics.
module hazard_unit_md #(
    parameter int REG_AW      = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [1:0]        tuse_rs_d,
    input  logic [1:0]        tuse_rt_d,
    input  logic              md_use_d,
    input  logic [REG_AW-1:0] a3_e,
    input  logic [REG_AW-1:0] a3_m,
    input  logic [1:0]        tnew_e,
    input  logic [1:0]        tnew_m,
    input  logic              md_start_e,
    input  logic              md_div_e,
    output logic              stall,
    output logic              en_pc,
    output logic              en_ifid,
    output logic              flush_idex,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  md_stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]       busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] md_stall_cnt_q, md_stall_cnt_d;

    logic haz_rs, haz_rt, haz_md, stall_int, md_only;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign md_busy = (busy_cnt_q != 4'd0);

    // Hazard detection: a source hazards when its producer in E or M is not
    // ready in time (Tuse < Tnew); $0 and Tuse=3 can never match.
    always_comb begin
        haz_rs    = (rs_d != '0) &&
                    (((rs_d == a3_e) && (tuse_rs_d < tnew_e)) ||
                     ((rs_d == a3_m) && (tuse_rs_d < tnew_m)));
        haz_rt    = (rt_d != '0) &&
                    (((rt_d == a3_e) && (tuse_rt_d < tnew_e)) ||
                     ((rt_d == a3_m) && (tuse_rt_d < tnew_m)));
        haz_md    = md_use_d && (md_busy || md_start_e);
        // Reset masks the stall so the pipeline can flow while clearing.
        stall_int = reset && (haz_rs || haz_rt || haz_md);
        md_only   = stall_int && haz_md && !haz_rs && !haz_rt;
    end

    assign stall      = stall_int;
    assign en_pc      = ~stall_int;
    assign en_ifid    = ~stall_int;
    assign flush_idex = stall_int;

    // Next-state for the md busy counter and the stall statistics.
    always_comb begin
        busy_cnt_d     = busy_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;

        // A start is only accepted when the unit is idle; starts while busy
        // are dropped silently.
        if (busy_cnt_q == 4'd0) begin
            if (md_start_e) begin
                busy_cnt_d = md_div_e ? DIV_LOAD : MULT_LOAD;
            end
        end else begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end

        if (stall_int) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (md_only) begin
            md_stall_cnt_d = sat_inc(md_stall_cnt_q);
        end
    end

    // State registers; reset aborts any md operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_cnt_q     <= 4'd0;
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            busy_cnt_q     <= busy_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_md.sv
// Scoreboard bench for hazard_unit_md: a driver issues per-cycle stimulus and
// pushes the expected response from a behavioural model; a monitor pops and
// compares every cycle. A second instance with CNT_W=4 checks saturation.
`timescale 1ns/1ps
module tb_hazard_unit_md;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] rs_d, rt_d, a3_e, a3_m;
    logic [1:0]    tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic          md_use_d, md_start_e, md_div_e;

    logic        stall, en_pc, en_ifid, flush_idex, md_busy;
    logic [31:0] stall_cnt, md_stall_cnt;
    logic        s_stall, s_en_pc, s_en_ifid, s_flush_idex, s_md_busy;
    logic [3:0]  s_stall_cnt, s_md_stall_cnt;

    hazard_unit_md #(.REG_AW(AW), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .md_use_d(md_use_d),
        .a3_e(a3_e), .a3_m(a3_m), .tnew_e(tnew_e), .tnew_m(tnew_m),
        .md_start_e(md_start_e), .md_div_e(md_div_e),
        .stall(stall), .en_pc(en_pc), .en_ifid(en_ifid), .flush_idex(flush_idex),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
    );

    hazard_unit_md #(.REG_AW(AW), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .md_use_d(md_use_d),
        .a3_e(a3_e), .a3_m(a3_m), .tnew_e(tnew_e), .tnew_m(tnew_m),
        .md_start_e(md_start_e), .md_div_e(md_div_e),
        .stall(s_stall), .en_pc(s_en_pc), .en_ifid(s_en_ifid), .flush_idex(s_flush_idex),
        .md_busy(s_md_busy), .stall_cnt(s_stall_cnt), .md_stall_cnt(s_md_stall_cnt)
    );

    typedef struct {
        logic          rst_n;
        logic [AW-1:0] rs, rt, a3e, a3m;
        logic [1:0]    tur, tut, tne, tnm;
        logic          mdu, start, div;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] sc, msc;
        logic [3:0]  sc4, msc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: md busy tracked as an absolute end edge.
    int unsigned m_edges    = 0;
    int unsigned m_busy_end = 0;
    int unsigned m_sc       = 0;
    int unsigned m_msc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic src_haz(input logic [AW-1:0] r, input logic [1:0] tu,
                                     input logic [AW-1:0] ae, input logic [1:0] te,
                                     input logic [AW-1:0] am, input logic [1:0] tm);
        if (r == 0) return 1'b0;
        return ((r == ae) && (tu < te)) || ((r == am) && (tu < tm));
    endfunction

    function automatic logic [3:0] sat15(input int unsigned v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1;
        s.rs = 0; s.rt = 0; s.a3e = 0; s.a3m = 0;
        s.tur = 2'd3; s.tut = 2'd3; s.tne = 0; s.tnm = 0;
        s.mdu = 0; s.start = 0; s.div = 0;
        return s;
    endfunction

    // One cycle of stimulus: drive, predict, advance the model past the edge.
    task automatic apply(input stim_t s);
        exp_t e;
        logic busy, hr, ht, hm, st;
        int unsigned n;
        @(negedge clk);
        reset = s.rst_n; rs_d = s.rs; rt_d = s.rt; a3_e = s.a3e; a3_m = s.a3m;
        tuse_rs_d = s.tur; tuse_rt_d = s.tut; tnew_e = s.tne; tnew_m = s.tnm;
        md_use_d = s.mdu; md_start_e = s.start; md_div_e = s.div;

        busy = (m_edges < m_busy_end);
        hr   = src_haz(s.rs, s.tur, s.a3e, s.tne, s.a3m, s.tnm);
        ht   = src_haz(s.rt, s.tut, s.a3e, s.tne, s.a3m, s.tnm);
        hm   = s.mdu && (busy || s.start);
        st   = s.rst_n && (hr || ht || hm);
        e.stall = st; e.busy = busy;
        e.sc = m_sc; e.msc = m_msc; e.sc4 = sat15(m_sc); e.msc4 = sat15(m_msc);
        exp_q.push_back(e);

        m_edges++;
        if (!s.rst_n) begin
            m_busy_end = 0; m_sc = 0; m_msc = 0;
        end else begin
            if (st) m_sc++;
            if (st && hm && !hr && !ht) m_msc++;
            if (s.start && !busy) begin
                n = s.div ? 10 : 5;
                m_busy_end = m_edges + n;
            end
        end
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(); s.rst_n = 1'b0;
        apply(s);
    endtask

    // Monitor: compares every cycle's outputs against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("en_pc", 32'(en_pc), 32'(!e.stall));
                chk("en_ifid", 32'(en_ifid), 32'(!e.stall));
                chk("flush_idex", 32'(flush_idex), 32'(e.stall));
                chk("md_busy", 32'(md_busy), 32'(e.busy));
                chk("stall_cnt", stall_cnt, e.sc);
                chk("md_stall_cnt", md_stall_cnt, e.msc);
                chk("sat_stall", 32'(s_stall), 32'(e.stall));
                chk("sat_md_busy", 32'(s_md_busy), 32'(e.busy));
                chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(e.sc4));
                chk("sat_md_stall_cnt", 32'(s_md_stall_cnt), 32'(e.msc4));
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b0; rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
        tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_e = 0; tnew_m = 0;
        md_use_d = 0; md_start_e = 0; md_div_e = 0;
        @(posedge clk);

        // Reset state
        do_reset();
        #2;
        chk("reset_stall", 32'(stall), 0);
        chk("reset_busy", 32'(md_busy), 0);

        // Load-use
        s = idle(); s.a3e = 8; s.tne = 2; s.rs = 8; s.tur = 1;
        apply(s); #2;
        chk("loaduse_stall", 32'(stall), 1);
        chk("loaduse_flush", 32'(flush_idex), 1);
        chk("loaduse_en_pc", 32'(en_pc), 0);
        s.tur = 2;
        apply(s); #2;
        chk("loaduse_tuse2", 32'(stall), 0);

        // $0 and unused operand
        s = idle(); s.a3e = 0; s.rs = 0; s.tne = 2; s.tur = 0;
        apply(s); #2;
        chk("zero_reg", 32'(stall), 0);
        s = idle(); s.rt = 5; s.a3m = 5; s.tnm = 1; s.tut = 3;
        apply(s); #2;
        chk("tuse3", 32'(stall), 0);

        // Div then mflo
        do_reset();
        s = idle(); s.mdu = 1; s.start = 1; s.div = 1;
        apply(s); #2;
        chk("div_start_stall", 32'(stall), 1);
        s.start = 0;
        for (int i = 0; i < 10; i++) begin
            apply(s); #2;
            chk("div_busy_stall", 32'(stall), 1);
        end
        apply(s); #2;
        chk("div_done_stall", 32'(stall), 0);
        chk("div_stall_cnt", stall_cnt, 11);
        chk("div_md_stall_cnt", md_stall_cnt, 11);

        // Back-to-back mult: second start ignored, start after fall reloads
        do_reset();
        s = idle(); s.start = 1;
        apply(s);
        s.start = 0; apply(s);
        s.start = 1; apply(s);
        s.start = 0; apply(s); apply(s); apply(s); #2;
        chk("mult_busy_c5", 32'(md_busy), 1);
        s.start = 1; apply(s); #2;
        chk("mult_busy_c6", 32'(md_busy), 0);
        s.start = 0; apply(s); #2;
        chk("mult_reload", 32'(md_busy), 1);
        for (int i = 0; i < 5; i++) apply(s);

        // Reset mid-div with hazards applied
        do_reset();
        s = idle(); s.start = 1; s.div = 1; s.mdu = 1;
        apply(s);
        s = idle();
        for (int i = 0; i < 4; i++) apply(s);
        s = idle(); s.rst_n = 0; s.a3e = 8; s.tne = 2; s.rs = 8; s.tur = 1; s.mdu = 1;
        apply(s); #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_en_pc", 32'(en_pc), 1);
        chk("rst_en_ifid", 32'(en_ifid), 1);
        chk("rst_flush", 32'(flush_idex), 0);
        s = idle(); apply(s); #2;
        chk("rst_abort_busy", 32'(md_busy), 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Saturation of the 4-bit counter
        do_reset();
        s = idle(); s.a3e = 8; s.tne = 2; s.rs = 8; s.tur = 1;
        for (int i = 0; i < 20; i++) apply(s);
        s = idle(); apply(s); #2;
        chk("sat_stop15", 32'(s_stall_cnt), 15);
        chk("sat_wide20", stall_cnt, 20);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 59) != 0);
            s.rs    = AW'($urandom_range(0, 3));
            s.rt    = AW'($urandom_range(0, 3));
            s.a3e   = AW'($urandom_range(0, 3));
            s.a3m   = AW'($urandom_range(0, 3));
            s.tur   = 2'($urandom_range(0, 3));
            s.tut   = 2'($urandom_range(0, 3));
            s.tne   = 2'($urandom_range(0, 2));
            s.tnm   = 2'($urandom_range(0, 2));
            s.mdu   = ($urandom_range(0, 2) == 0);
            s.start = ($urandom_range(0, 5) == 0);
            s.div   = 1'($urandom_range(0, 1));
            apply(s);
        end

        repeat (2) @(negedge clk);
        #4;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
